// File: rtl/l2_amo_rmw_ctrl.sv
// L2 atomic read-modify-write sequencer: reads the target line, steps the AMO ALU through its
// load and result cycles, writes the updated line back and returns the old line to the requester.
module l2_amo_rmw_ctrl #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 40,
    parameter int OP_W       = 4,
    parameter int SIZE_W     = 3,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_val,
    output logic              req_rdy,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [SIZE_W-1:0] req_size,
    input  logic [DATA_W-1:0] req_data,
    output logic              rd_val,
    input  logic              rd_rdy,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data_val,
    input  logic [DATA_W-1:0] rd_data,
    output logic [OP_W-1:0]   alu_op,
    output logic [ADDR_W-1:0] alu_addr,
    output logic [SIZE_W-1:0] alu_size,
    output logic [DATA_W-1:0] alu_mem_opnd,
    output logic [DATA_W-1:0] alu_cpu_opnd,
    output logic              alu_stall,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wr_val,
    input  logic              wr_rdy,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              busy
);

    localparam logic [OP_W-1:0]   OP_NOP   = '0;
    localparam logic [SIZE_W-1:0] SIZE_1B  = SIZE_W'(1);
    localparam logic [SIZE_W-1:0] SIZE_2B  = SIZE_W'(2);
    localparam logic [SIZE_W-1:0] SIZE_4B  = SIZE_W'(3);
    localparam logic [SIZE_W-1:0] SIZE_8B  = SIZE_W'(4);
    localparam logic [7:0]        TMO_LAST = 8'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_ALU_LOAD, S_ALU_RES, S_WR, S_RESP
    } state_t;

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SIZE_W-1:0] size_q;
    logic [DATA_W-1:0] cpu_q;
    logic [DATA_W-1:0] mem_q;
    logic [7:0]        tmo_cnt;
    logic              req_bad;

    // NOTE: default assignment first keeps this decode latch-free.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SIZE_1B: req_bad = 1'b0;
            SIZE_2B: req_bad = req_addr[0];
            SIZE_4B: req_bad = |req_addr[1:0];
            SIZE_8B: req_bad = |req_addr[2:0];
            default: req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            cpu_q    <= '0;
            mem_q    <= '0;
            wr_data  <= '0;
            tmo_cnt  <= '0;
            rd_val   <= 1'b0;
            wr_val   <= 1'b0;
            resp_val <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_val) begin
                        op_q     <= req_op;
                        addr_q   <= req_addr;
                        size_q   <= req_size;
                        cpu_q    <= req_data;
                        mem_q    <= '0;
                        resp_err <= req_bad;
                        if (req_bad) begin
                            resp_val <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            rd_val <= 1'b1;
                            state  <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (rd_rdy) begin
                        rd_val  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // A strobe arriving on the last counted cycle still wins over the abort.
                    if (rd_data_val) begin
                        mem_q <= rd_data;
                        state <= S_ALU_LOAD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        resp_err <= 1'b1;
                        resp_val <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_ALU_LOAD: state <= S_ALU_RES;
                S_ALU_RES: begin
                    wr_data <= alu_result;
                    if (op_q == OP_NOP) begin
                        resp_val <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        wr_val <= 1'b1;
                        state  <= S_WR;
                    end
                end
                S_WR: begin
                    if (wr_rdy) begin
                        wr_val   <= 1'b0;
                        resp_val <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_rdy) begin
                        resp_val <= 1'b0;
                        resp_err <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_rdy      = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign alu_stall    = (state != S_ALU_LOAD);
    assign rd_addr      = addr_q;
    assign wr_addr      = addr_q;
    assign alu_op       = op_q;
    assign alu_addr     = addr_q;
    assign alu_size     = size_q;
    assign alu_cpu_opnd = cpu_q;
    assign alu_mem_opnd = mem_q;
    assign resp_data    = mem_q;

endmodule

// File: tb/tb_l2_amo_rmw_ctrl.sv
// Bench for l2_amo_rmw_ctrl: plays data array, AMO ALU and requester, and compares every
// transaction against a line-level memory model and an arithmetic AMO model.
module tb_l2_amo_rmw_ctrl;

    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 40;
    localparam int OP_W       = 4;
    localparam int SIZE_W     = 3;
    localparam int RD_TIMEOUT = 255;

    typedef logic [DATA_W-1:0] line_t;

    localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_MAX  = 4'd5;
    localparam logic [OP_W-1:0] OP_MAXU = 4'd6;
    localparam logic [OP_W-1:0] OP_MIN  = 4'd7;
    localparam logic [OP_W-1:0] OP_MINU = 4'd8;
    localparam logic [OP_W-1:0] OP_SWAP = 4'd9;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_val, req_rdy;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [SIZE_W-1:0] req_size;
    line_t             req_data;
    logic              rd_val, rd_rdy;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data_val;
    line_t             rd_data;
    logic [OP_W-1:0]   alu_op;
    logic [ADDR_W-1:0] alu_addr;
    logic [SIZE_W-1:0] alu_size;
    line_t             alu_mem_opnd, alu_cpu_opnd;
    logic              alu_stall;
    line_t             alu_result;
    logic              wr_val, wr_rdy;
    logic [ADDR_W-1:0] wr_addr;
    line_t             wr_data;
    logic              resp_val, resp_rdy;
    line_t             resp_data;
    logic              resp_err;
    logic              busy;

    int    total = 0;
    int    bad   = 0;
    line_t mem [int];
    line_t last_wr, last_resp;

    l2_amo_rmw_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .SIZE_W(SIZE_W), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_addr(req_addr),
        .req_size(req_size), .req_data(req_data),
        .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
        .rd_data_val(rd_data_val), .rd_data(rd_data),
        .alu_op(alu_op), .alu_addr(alu_addr), .alu_size(alu_size),
        .alu_mem_opnd(alu_mem_opnd), .alu_cpu_opnd(alu_cpu_opnd),
        .alu_stall(alu_stall), .alu_result(alu_result),
        .wr_val(wr_val), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input line_t got, input line_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic line_t rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int size_bytes(input logic [SIZE_W-1:0] sz);
        case (sz)
            3'd1:    return 1;
            3'd2:    return 2;
            3'd3:    return 4;
            3'd4:    return 8;
            default: return 0;
        endcase
    endfunction

    // Operand lives at the same byte lanes of the memory line and the cpu line.
    function automatic line_t amo_calc(input logic [OP_W-1:0] op, input int nb, input int off,
                                       input line_t m, input line_t c);
        logic [63:0]        a, b, r, mask;
        logic signed [63:0] sa, sb;
        line_t              res;
        int                 w;
        w    = nb * 8;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a    = 64'(m >> (off * 8)) & mask;
        b    = 64'(c >> (off * 8)) & mask;
        sa   = a[w-1] ? (a | ~mask) : a;
        sb   = b[w-1] ? (b | ~mask) : b;
        case (op)
            OP_ADD:  r = a + b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MAX:  r = (sa > sb) ? a : b;
            OP_MAXU: r = (a > b) ? a : b;
            OP_MIN:  r = (sa < sb) ? a : b;
            OP_MINU: r = (a < b) ? a : b;
            OP_SWAP: r = b;
            default: r = a;
        endcase
        r   = r & mask;
        res = m & ~(line_t'(mask) << (off * 8));
        res = res | (line_t'(r) << (off * 8));
        return res;
    endfunction

    task automatic run_txn(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [SIZE_W-1:0] sz, input line_t cpu, input int rd_lat,
                           input int rd_bp, input int wr_bp, input int resp_bp,
                           input bit drop_strobe, input bit rst_in_wr);
        int    nb, key, t, t_wait, t_load, t_strobe, lat_left;
        int    rd_hs, wr_hs, resp_hs, n_load, rd_bp_left, wr_bp_left, resp_bp_left;
        bit    ok, exp_err, exp_wr, drive_res, done, seen_wr, seen_resp;
        line_t old_line, new_line, exp_resp;

        nb  = size_bytes(sz);
        ok  = (nb != 0) && ((int'(addr[3:0]) % (nb == 0 ? 1 : nb)) == 0);
        key = int'(addr >> 4);
        if (!mem.exists(key)) mem[key] = rand_line();
        old_line = mem[key];
        new_line = ok ? amo_calc(op, nb, int'(addr[3:0]), old_line, cpu) : old_line;
        exp_err  = !ok || drop_strobe;
        exp_wr   = ok && !drop_strobe && (op != OP_NOP);
        exp_resp = exp_err ? '0 : old_line;

        t = 0; t_wait = -1; t_load = -1; t_strobe = -1; lat_left = -1;
        rd_hs = 0; wr_hs = 0; resp_hs = 0; n_load = 0;
        rd_bp_left = rd_bp; wr_bp_left = wr_bp; resp_bp_left = resp_bp;
        drive_res = 0; done = 0; seen_wr = 0; seen_resp = 0;

        @(negedge clk);
        check("req_rdy_idle", req_rdy, 1'b1);
        req_val = 1; req_op = op; req_addr = addr; req_size = sz; req_data = cpu;
        @(negedge clk);
        req_val = 0; req_op = OP_W'($urandom); req_addr = ADDR_W'($urandom); req_data = rand_line();
        check("busy_after_accept", busy, 1'b1);
        check("req_rdy_while_busy", req_rdy, 1'b0);

        while (!done && t < 600) begin
            rd_data_val = 0;
            rd_data     = rand_line();
            if (rd_val) begin
                check("rd_addr", rd_addr, addr);
                rd_data_val = 1'($urandom_range(0, 1));
                if (rd_bp_left > 0) begin rd_rdy = 0; rd_bp_left--; end
                else begin rd_rdy = 1; rd_hs++; end
            end else begin
                rd_rdy = 1'($urandom_range(0, 1));
                if (t_wait < 0 && rd_hs > 0) begin t_wait = t; lat_left = rd_lat; end
                if (lat_left == 0 && !drop_strobe) begin
                    rd_data_val = 1; rd_data = old_line; t_strobe = t;
                end else if (lat_left < 0 && (t_load >= 0 || !ok)) begin
                    rd_data_val = 1'($urandom_range(0, 1));
                end
                if (lat_left >= 0) lat_left--;
            end

            alu_result = drive_res ? new_line : rand_line();
            if (drive_res) begin
                check("alu_stall_res", alu_stall, 1'b1);
                check("alu_op_held", alu_op, op);
                check("alu_mem_held", alu_mem_opnd, old_line);
            end
            drive_res = 0;
            if (!alu_stall) begin
                n_load++;
                t_load = t;
                check("load_after_strobe", t - t_strobe, 1);
                check("alu_op", alu_op, op);
                check("alu_addr", alu_addr, addr);
                check("alu_size", alu_size, sz);
                check("alu_mem_opnd", alu_mem_opnd, old_line);
                check("alu_cpu_opnd", alu_cpu_opnd, cpu);
                drive_res = 1;
            end

            if (wr_val) begin
                if (!seen_wr) begin
                    seen_wr = 1;
                    check("wr_after_load", t - t_load, 2);
                end
                check("wr_addr", wr_addr, addr);
                check("wr_data", wr_data, new_line);
                last_wr = wr_data;
                if (rst_in_wr) begin
                    wr_rdy = 0;
                    rst = 1;
                    #1;
                    check("rst_wr_val", wr_val, 1'b0);
                    check("rst_busy", busy, 1'b0);
                    check("rst_resp_val", resp_val, 1'b0);
                    check("rst_alu_stall", alu_stall, 1'b1);
                    @(negedge clk);
                    rst = 0;
                    for (int i = 0; i < 3; i++) begin
                        wr_rdy = 1; resp_rdy = 1;
                        @(negedge clk);
                        check("no_wr_after_rst", wr_val, 1'b0);
                        check("no_resp_after_rst", resp_val, 1'b0);
                    end
                    wr_rdy = 0; resp_rdy = 0; rd_data_val = 0;
                    return;
                end
                if (wr_bp_left > 0) begin wr_rdy = 0; wr_bp_left--; end
                else begin wr_rdy = 1; wr_hs++; end
            end else begin
                wr_rdy = 1'($urandom_range(0, 1));
            end

            if (resp_val) begin
                if (!seen_resp) begin
                    seen_resp = 1;
                    if (!ok) check("err_resp_latency", t <= 1, 1'b1);
                    if (drop_strobe && ok) check("timeout_latency", t - t_wait, RD_TIMEOUT);
                end
                check("resp_err", resp_err, exp_err);
                check("resp_data", resp_data, exp_resp);
                last_resp = resp_data;
                if (resp_bp_left > 0) begin resp_rdy = 0; resp_bp_left--; end
                else begin resp_rdy = 1; resp_hs++; done = 1; end
            end else begin
                resp_rdy = 1'($urandom_range(0, 1));
            end

            @(negedge clk);
            t++;
        end

        check("txn_completed", done, 1'b1);
        check("req_rdy_after_resp", req_rdy, 1'b1);
        check("busy_after_resp", busy, 1'b0);
        check("resp_val_dropped", resp_val, 1'b0);
        check("rd_handshakes", rd_hs, ok ? 1 : 0);
        check("wr_handshakes", wr_hs, exp_wr ? 1 : 0);
        check("alu_load_cycles", n_load, (ok && !drop_strobe) ? 1 : 0);
        check("resp_handshakes", resp_hs, 1);
        if (exp_wr) mem[key] = new_line;
        rd_rdy = 0; wr_rdy = 0; resp_rdy = 0; rd_data_val = 0;
    endtask

    initial begin
        rst = 1; req_val = 0; req_op = '0; req_addr = '0; req_size = '0; req_data = '0;
        rd_rdy = 0; rd_data_val = 0; rd_data = '0; alu_result = '0;
        wr_rdy = 0; resp_rdy = 0;
        last_wr = '0; last_resp = '0;
        repeat (3) @(negedge clk);
        check("rst_req_rdy", req_rdy, 1'b1);
        check("rst_busy0", busy, 1'b0);
        check("rst_rd_val", rd_val, 1'b0);
        check("rst_wr_val0", wr_val, 1'b0);
        check("rst_resp_val0", resp_val, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_stall", alu_stall, 1'b1);
        check("rst_wr_data", wr_data, '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_rd_addr", rd_addr, '0);
        rst = 0;

        // 8B ADD at dword 1
        mem[0] = {64'd5, 64'h1234_5678_9abc_def0};
        run_txn(OP_ADD, 40'h8, 3'd4, {64'd3, 64'hdead_beef_0000_1111}, 1, 0, 0, 0, 0, 0);
        check("add_dw1_new", last_wr[127:64], 64'd8);
        check("add_dw0_kept", last_wr[63:0], 64'h1234_5678_9abc_def0);
        check("add_dw1_old", last_resp[127:64], 64'd5);

        // 4B MINU unsigned, then 4B MAX signed
        mem[0] = {64'h5555_6666_7777_8888, 32'h10, 32'hbbbb_bbbb};
        run_txn(OP_MINU, 40'h4, 3'd3, {64'h0, 32'hffff_ffff, 32'h0}, 0, 0, 0, 0, 0, 0);
        check("minu_word", last_wr[63:32], 32'h10);
        mem[0] = {64'h5555_6666_7777_8888, 32'h10, 32'h8000_0000};
        run_txn(OP_MAX, 40'h0, 3'd3, {96'h0, 32'h1}, 2, 0, 0, 0, 0, 0);
        check("max_signed_word", last_wr[31:0], 32'h1);

        // Plain load: no write, old line back
        run_txn(OP_NOP, 40'h0, 3'd4, rand_line(), 1, 0, 0, 0, 0, 0);
        check("nop_old_line", last_resp, mem[0]);

        // Misaligned and unknown sizes
        run_txn(OP_ADD, 40'h2, 3'd3, rand_line(), 0, 0, 0, 0, 0, 0);
        run_txn(OP_ADD, 40'h1, 3'd2, rand_line(), 0, 0, 0, 0, 0, 0);
        run_txn(OP_XOR, 40'h4, 3'd4, rand_line(), 0, 0, 0, 0, 0, 0);
        run_txn(OP_OR,  40'h0, 3'd0, rand_line(), 0, 0, 0, 0, 0, 0);
        run_txn(OP_OR,  40'h0, 3'd5, rand_line(), 0, 0, 0, 0, 0, 0);

        // Read data never arrives
        run_txn(OP_ADD, 40'h10, 3'd4, rand_line(), 0, 0, 0, 0, 1, 0);

        // Backpressure on every channel
        run_txn(OP_ADD, 40'h18, 3'd3, rand_line(), 2, 5, 5, 5, 0, 0);

        // Reset while the write is stalled, then the same request completes
        run_txn(OP_SWAP, 40'h20, 3'd4, rand_line(), 1, 0, 5, 0, 0, 1);
        run_txn(OP_SWAP, 40'h20, 3'd4, rand_line(), 1, 0, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [SIZE_W-1:0] sz;
            logic [ADDR_W-1:0] a;
            int                nb;
            sz = ($urandom_range(0, 9) == 0) ? SIZE_W'($urandom_range(0, 7)) : SIZE_W'($urandom_range(1, 4));
            nb = size_bytes(sz);
            a  = ADDR_W'($urandom_range(0, 63));
            if (nb != 0 && $urandom_range(0, 6) != 0) a = a & ~ADDR_W'(nb - 1);
            run_txn(OP_W'($urandom_range(0, 9)), a, sz, rand_line(), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
